div_unit: RTL

- Iterative RV32M divider in the execute stage. Handles DIV, DIVU, REM and REMU.
- Accepts operands from the ID/EX register and holds the pipeline with busy_out while it runs.
- Drives result_out into data1_in of the writeback 2:1 mux; that mux's sel is driven by done_out.
- Radix-2 restoring algorithm, one quotient bit per cycle.

---
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// Operand/result handshake between the ID/EX pipeline and the iterative divider.
interface div_unit_if #(
  parameter int XLEN = 32
);
  logic            start_in;
  logic [1:0]      op_in;
  logic [XLEN-1:0] dividend_in;
  logic [XLEN-1:0] divisor_in;
  logic            flush_in;
  logic            busy_out;
  logic            done_out;
  logic [XLEN-1:0] result_out;

  modport master (
    output start_in, op_in, dividend_in, divisor_in, flush_in,
    input  busy_out, done_out, result_out
  );

  modport slave (
    input  start_in, op_in, dividend_in, divisor_in, flush_in,
    output busy_out, done_out, result_out
  );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  div_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};

  state_t                  state;
  logic [XLEN-1:0]         rem_p0;
  logic [XLEN-1:0]         quo_p0;
  logic [XLEN-1:0]         dvsr_p0;
  logic [CNT_W-1:0]        cnt_p0;
  logic                    neg_q_p0;
  logic                    neg_r_p0;
  logic                    is_rem_p0;
  logic                    busy;
  logic                    done;
  logic [XLEN-1:0]         result;

  logic                    op_signed;
  logic                    op_rem;
  logic                    dvd_neg;
  logic                    dvs_neg;
  logic [XLEN-1:0]         dvd_abs;
  logic [XLEN-1:0]         dvs_abs;
  logic                    div_zero;
  logic                    ovf;
  logic                    special;
  logic [XLEN-1:0]         spec_res;
  logic                    accept;
  logic signed [XLEN:0]    trial;
  logic [XLEN-1:0]         rem_nxt;
  logic [XLEN-1:0]         quo_nxt;
  logic [XLEN-1:0]         fin_res;
  logic                    last_iter;

  // Conditional two's-complement negation; wrap of the most negative value is intended.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Start capture: operand magnitudes, signs and one-cycle special results
  always_comb begin
    op_signed = ~bus.op_in[0];
    op_rem    = bus.op_in[1];
    dvd_neg   = op_signed & bus.dividend_in[XLEN-1];
    dvs_neg   = op_signed & bus.divisor_in[XLEN-1];
    dvd_abs   = cond_neg(bus.dividend_in, dvd_neg);
    dvs_abs   = cond_neg(bus.divisor_in, dvs_neg);
    div_zero  = (bus.divisor_in == '0);
    ovf       = op_signed & (bus.dividend_in == SMIN) & (bus.divisor_in == ONES);
    special   = div_zero | ovf;
    spec_res  = '0;
    if (div_zero) begin
      spec_res = op_rem ? bus.dividend_in : ONES;
    end else if (ovf) begin
      spec_res = op_rem ? '0 : SMIN;
`ifdef DIV_EARLY_OUT_EN
    end else if (dvd_abs < dvs_abs) begin
      special  = 1'b1;
      spec_res = op_rem ? bus.dividend_in : '0;
`endif
    end
    accept = bus.start_in & ~bus.flush_in;
  end

  // Iteration: trial subtract keeps the shifted-out remainder MSB in bit XLEN
  always_comb begin
    trial = $signed({rem_p0, quo_p0[XLEN-1]}) - $signed({1'b0, dvsr_p0});
    if (!trial[XLEN]) begin
      rem_nxt = trial[XLEN-1:0];
      quo_nxt = {quo_p0[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = {rem_p0[XLEN-2:0], quo_p0[XLEN-1]};
      quo_nxt = {quo_p0[XLEN-2:0], 1'b0};
    end
    fin_res   = is_rem_p0 ? cond_neg(rem_nxt, neg_r_p0) : cond_neg(quo_nxt, neg_q_p0);
    last_iter = (cnt_p0 == CNT_W'(XLEN-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem_p0    <= '0;
      quo_p0    <= '0;
      dvsr_p0   <= '0;
      cnt_p0    <= '0;
      neg_q_p0  <= 1'b0;
      neg_r_p0  <= 1'b0;
      is_rem_p0 <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        CALC: begin
          if (bus.flush_in) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            rem_p0 <= rem_nxt;
            quo_p0 <= quo_nxt;
            cnt_p0 <= cnt_p0 + 1'b1;
            if (last_iter) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= fin_res;
            end
          end
        end
        default: begin
          // IDLE and DONE accept a new operation identically, enabling back-to-back issue
          if (accept && special) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= spec_res;
          end else if (accept) begin
            state     <= CALC;
            busy      <= 1'b1;
            done      <= 1'b0;
            rem_p0    <= '0;
            quo_p0    <= dvd_abs;
            dvsr_p0   <= dvs_abs;
            cnt_p0    <= '0;
            neg_q_p0  <= dvd_neg ^ dvs_neg;
            neg_r_p0  <= dvd_neg;
            is_rem_p0 <= op_rem;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy_out   = busy;
  assign bus.done_out   = done;
  assign bus.result_out = result;

endmodule
